// File: rtl/idu_load_queue.sv
// ---------------------------------------------------------------------------
// idu_load_queue
//
// Holds load instructions from the decoder and hands them to the DFU one at a
// time. Decoded instructions whose opcode byte is not LOAD_OPCODE are accepted
// and discarded. Each discard bumps a saturating drop counter. A three-state
// pop FSM (IDLE/ISSUE/BUSY) issues the queue head on a DFU request. It then
// waits for the DFU's done pulse before it accepts another request.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   dec2idu_instr/_vld         instruction push from the decoder
//   idu2dec_instr_rdy          queue has room (count != DEPTH)
//   idu2dfu_load_fifo_empty    no load instruction queued
//   dfu2idu_load_instr_req     DFU pop request pulse
//   idu2dfu_load_instr/_vld    popped instruction (registered) + 1-cycle valid
//   dfu2idu_load_instr_done    DFU completion pulse
//   idu_load_count             queued entry count
//   idu_load_drop_cnt          discarded non-load count, saturates at 255
//   idu_load_busy              an instruction is issued and not yet done
//   idu_load_err               sticky protocol error
// ---------------------------------------------------------------------------
module idu_load_queue #(
  parameter int         INSTR_WIDTH = 256,
  parameter int         DEPTH       = 8,
  parameter logic [7:0] LOAD_OPCODE = 8'h01
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INSTR_WIDTH-1:0]   dec2idu_instr,
  input  logic                     dec2idu_instr_vld,
  output logic                     idu2dec_instr_rdy,
  output logic                     idu2dfu_load_fifo_empty,
  input  logic                     dfu2idu_load_instr_req,
  output logic [INSTR_WIDTH-1:0]   idu2dfu_load_instr,
  output logic                     idu2dfu_load_instr_vld,
  input  logic                     dfu2idu_load_instr_done,
  output logic [$clog2(DEPTH):0]   idu_load_count,
  output logic [7:0]               idu_load_drop_cnt,
  output logic                     idu_load_busy,
  output logic                     idu_load_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic                    err_q, err_d;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_d;

  // Entry storage; contents survive reset, only the pointers are cleared.
  logic [INSTR_WIDTH-1:0]  queue_mem [DEPTH];

  logic empty;
  logic push;
  logic push_load;
  logic push_drop;
  logic pop;

  assign empty     = (count_q == '0);
  assign push      = dec2idu_instr_vld && (count_q != FULL_COUNT);
  assign push_load = push && (dec2idu_instr[7:0] == LOAD_OPCODE);
  assign push_drop = push && (dec2idu_instr[7:0] != LOAD_OPCODE);
  // Emptiness comes from the registered count, so a load pushed in the
  // same cycle can never be popped in that cycle.
  assign pop       = (state_q == S_IDLE) && dfu2idu_load_instr_req && !empty;

  always_ff @(posedge clk) begin
    if (push_load) begin
      queue_mem[wr_ptr_q] <= dec2idu_instr;
    end
  end

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    instr_d    = instr_q;

    if (push_load) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (push_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      instr_d  = queue_mem[rd_ptr_q];
    end

    case ({push_load, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pop FSM next state plus protocol error detection.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_ISSUE;
        end
        if (dfu2idu_load_instr_req && empty) begin
          err_d = 1'b1;
        end
        if (dfu2idu_load_instr_done) begin
          err_d = 1'b1;
        end
      end
      S_ISSUE: begin
        // A done arriving already in the issue cycle completes immediately.
        state_d = dfu2idu_load_instr_done ? S_IDLE : S_BUSY;
        if (dfu2idu_load_instr_req) begin
          err_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (dfu2idu_load_instr_done) begin
          state_d = S_IDLE;
        end
        if (dfu2idu_load_instr_req) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
      instr_q    <= instr_d;
    end
  end

  assign idu2dec_instr_rdy       = (count_q != FULL_COUNT);
  assign idu2dfu_load_fifo_empty = empty;
  assign idu2dfu_load_instr      = instr_q;
  assign idu2dfu_load_instr_vld  = (state_q == S_ISSUE);
  assign idu_load_count          = count_q;
  assign idu_load_drop_cnt       = drop_cnt_q;
  assign idu_load_busy           = (state_q == S_ISSUE) || (state_q == S_BUSY);
  assign idu_load_err            = err_q;

endmodule

// File: tb/tb_idu_load_queue.sv
// ---------------------------------------------------------------------------
// tb_idu_load_queue
//
// Self-checking bench for idu_load_queue. A reference model uses a queue of
// instructions, a drop counter, a sticky error bit and an outstanding flag.
// Directed tasks cover ordering, full/wrap, dropping, protocol errors,
// simultaneous push/pop and mid-operation reset. A randomized task compares
// every output against the model each cycle.
// ---------------------------------------------------------------------------
module tb_idu_load_queue;

  localparam int W  = 256;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          din_vld;
  logic          rdy;
  logic          empty;
  logic          req;
  logic [W-1:0]  dout;
  logic          dvld;
  logic          done;
  logic [CW-1:0] cnt;
  logic [7:0]    drop;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] mq[$];
  int           m_drop;
  bit           m_err;
  bit           m_busy;
  bit           m_vld;
  logic [W-1:0] m_out;

  always #5 clk = ~clk;

  idu_load_queue #(
    .INSTR_WIDTH (W),
    .DEPTH       (D),
    .LOAD_OPCODE (8'h01)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .dec2idu_instr           (din),
    .dec2idu_instr_vld       (din_vld),
    .idu2dec_instr_rdy       (rdy),
    .idu2dfu_load_fifo_empty (empty),
    .dfu2idu_load_instr_req  (req),
    .idu2dfu_load_instr      (dout),
    .idu2dfu_load_instr_vld  (dvld),
    .dfu2idu_load_instr_done (done),
    .idu_load_count          (cnt),
    .idu_load_drop_cnt       (drop),
    .idu_load_busy           (busy),
    .idu_load_err            (err)
  );

  function automatic logic [W-1:0] mk(input logic [7:0] op);
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    r[7:0] = op;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drop = 0;
    m_err  = 1'b0;
    m_busy = 1'b0;
    m_vld  = 1'b0;
    m_out  = '0;
  endtask

  // Advance the model using the inputs currently applied, clock once, then
  // drop the pulse inputs. Returns at posedge + 1.
  task automatic cycle();
    bit full, emp, push, pop;
    full = (mq.size() == D);
    emp  = (mq.size() == 0);
    push = din_vld && !full;
    pop  = !m_busy && req && !emp;
    if (req && (m_busy || emp)) m_err = 1'b1;
    if (done && !m_busy) m_err = 1'b1;
    m_vld = pop;
    if (pop) begin
      m_out  = mq.pop_front();
      m_busy = 1'b1;
    end else if (done && m_busy) begin
      m_busy = 1'b0;
    end
    if (push) begin
      if (din[7:0] == 8'h01) mq.push_back(din);
      else if (m_drop < 255) m_drop++;
    end
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    req     = 1'b0;
    done    = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    din_vld = 1'b0;
    req     = 1'b0;
    done    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] a;
    rst = 1'b1; din = '0; din_vld = 1'b0; req = 1'b0; done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cnt !== 4'd0 || empty !== 1'b1 || rdy !== 1'b1 || busy !== 1'b0 ||
        dvld !== 1'b0 || err !== 1'b0 || drop !== 8'd0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d empty=%b rdy=%b busy=%b vld=%b err=%b drop=%0d dout0=%h, required 0 1 1 0 0 0 0 0",
               cnt, empty, rdy, busy, dvld, err, drop, dout[31:0]);
    end
    rst = 1'b0;
    a = mk(8'h01);
    din = a; din_vld = 1'b1;
    cycle();
    checks++;
    if (cnt !== 4'd1) begin
      errors++;
      $display("FAIL first_push_after_reset: cnt=%0d required 1", cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_fifo_order();
    logic [W-1:0] items[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      items[i] = mk(8'h01);
      din = items[i]; din_vld = 1'b1;
      cycle();
    end
    checks++;
    if (cnt !== 4'd3) begin
      errors++;
      $display("FAIL order_count_after_push: cnt=%0d required 3", cnt);
    end
    for (int i = 0; i < 3; i++) begin
      req = 1'b1;
      cycle();
      checks++;
      if (dvld !== 1'b1 || dout !== items[i] || cnt !== 4'(2 - i)) begin
        errors++;
        $display("FAIL order_pop%0d: vld=%b dout0=%h cnt=%0d, required vld=1 dout0=%h cnt=%0d",
                 i, dvld, dout[31:0], cnt, items[i][31:0], 2 - i);
      end
      cycle();
      checks++;
      if (dvld !== 1'b0 || busy !== 1'b1 || dout !== items[i]) begin
        errors++;
        $display("FAIL order_busy%0d: vld=%b busy=%b dout0=%h, required 0 1 %h",
                 i, dvld, busy, dout[31:0], items[i][31:0]);
      end
      done = 1'b1;
      cycle();
    end
    checks++;
    if (empty !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL order_final: empty=%b busy=%b err=%b, required 1 0 0", empty, busy, err);
    end
    $display("test_fifo_order done");
  endtask

  task automatic test_full_wrap();
    logic [W-1:0] items[D];
    logic [W-1:0] extra;
    do_reset();
    for (int i = 0; i < D; i++) begin
      items[i] = mk(8'h01);
      din = items[i]; din_vld = 1'b1;
      cycle();
    end
    checks++;
    if (rdy !== 1'b0 || cnt !== 4'd8) begin
      errors++;
      $display("FAIL full_state: rdy=%b cnt=%0d, required 0 8", rdy, cnt);
    end
    din = mk(8'h01); din_vld = 1'b1;
    cycle();
    checks++;
    if (cnt !== 4'd8) begin
      errors++;
      $display("FAIL full_reject: cnt=%0d required 8", cnt);
    end
    req = 1'b1;
    cycle();
    checks++;
    if (rdy !== 1'b1 || dvld !== 1'b1 || dout !== items[0]) begin
      errors++;
      $display("FAIL full_pop: rdy=%b vld=%b dout0=%h, required 1 1 %h", rdy, dvld, dout[31:0], items[0][31:0]);
    end
    // done lands in the issue cycle, push refills the freed slot
    extra = mk(8'h01);
    din = extra; din_vld = 1'b1; done = 1'b1;
    cycle();
    checks++;
    if (cnt !== 4'd8 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_push: cnt=%0d busy=%b err=%b, required 8 0 0", cnt, busy, err);
    end
    for (int i = 1; i <= D; i++) begin
      req = 1'b1;
      cycle();
      checks++;
      if (dvld !== 1'b1 || dout !== ((i == D) ? extra : items[i])) begin
        errors++;
        $display("FAIL wrap_drain%0d: vld=%b dout0=%h, required 1 %h", i, dvld, dout[31:0],
                 ((i == D) ? extra[31:0] : items[i][31:0]));
      end
      done = 1'b1;
      cycle();
    end
    checks++;
    if (empty !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_final: empty=%b err=%b, required 1 0", empty, err);
    end
    $display("test_full_wrap done");
  endtask

  task automatic test_drop();
    do_reset();
    din = mk(8'h02); din_vld = 1'b1;
    cycle();
    din = mk(8'h01); din_vld = 1'b1;
    cycle();
    checks++;
    if (drop !== 8'd1 || cnt !== 4'd1) begin
      errors++;
      $display("FAIL drop_one: drop=%0d cnt=%0d, required 1 1", drop, cnt);
    end
    for (int i = 0; i < 300; i++) begin
      din = mk(8'($urandom_range(2, 255))); din_vld = 1'b1;
      cycle();
    end
    checks++;
    if (drop !== 8'd255 || cnt !== 4'd1) begin
      errors++;
      $display("FAIL drop_saturate: drop=%0d cnt=%0d, required 255 1", drop, cnt);
    end
    $display("test_drop done");
  endtask

  task automatic test_err();
    do_reset();
    req = 1'b1;
    cycle();
    checks++;
    if (dvld !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_req_empty: vld=%b err=%b busy=%b, required 0 1 0", dvld, err, busy);
    end
    repeat (3) cycle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      din = mk(8'h01); din_vld = 1'b1;
      cycle();
    end
    req = 1'b1;
    cycle();
    cycle();
    req = 1'b1;
    cycle();
    checks++;
    if (cnt !== 4'd1 || err !== 1'b1 || dvld !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_req_busy: cnt=%0d err=%b vld=%b busy=%b, required 1 1 0 1", cnt, err, dvld, busy);
    end
    do_reset();
    done = 1'b1;
    cycle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_done_idle: err=%b required 1", err);
    end
    $display("test_err done");
  endtask

  task automatic test_push_pop_same();
    logic [W-1:0] a, b;
    do_reset();
    a = mk(8'h01);
    b = mk(8'h01);
    din = a; din_vld = 1'b1;
    cycle();
    din = b; din_vld = 1'b1; req = 1'b1;
    cycle();
    checks++;
    if (dvld !== 1'b1 || dout !== a || cnt !== 4'd1) begin
      errors++;
      $display("FAIL same_cycle_pushpop: vld=%b dout0=%h cnt=%0d, required 1 %h 1", dvld, dout[31:0], cnt, a[31:0]);
    end
    do_reset();
    din = a; din_vld = 1'b1; req = 1'b1;
    cycle();
    checks++;
    if (dvld !== 1'b0 || cnt !== 4'd1 || err !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_empty: vld=%b cnt=%0d err=%b, required 0 1 1", dvld, cnt, err);
    end
    $display("test_push_pop_same done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      din = mk(8'h01); din_vld = 1'b1;
      cycle();
    end
    req = 1'b1;
    cycle();
    cycle();
    checks++;
    if (busy !== 1'b1 || cnt !== 4'd4) begin
      errors++;
      $display("FAIL midrst_pre: busy=%b cnt=%0d, required 1 4", busy, cnt);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || cnt !== 4'd0 || empty !== 1'b1 || dvld !== 1'b0 || rdy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: busy=%b cnt=%0d empty=%b vld=%b rdy=%b err=%b, required 0 0 1 0 1 0",
               busy, cnt, empty, dvld, rdy, err);
    end
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_done_in_reset: err=%b busy=%b, required 0 0", err, busy);
    end
    rst = 1'b0;
    done = 1'b1;
    cycle();
    checks++;
    if (err !== 1'b1 || cnt !== 4'd0) begin
      errors++;
      $display("FAIL midrst_done_after: err=%b cnt=%0d, required 1 0", err, cnt);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if (n % 250 == 249) do_reset();
      din     = mk(($urandom_range(0, 9) < 7) ? 8'h01 : 8'($urandom_range(2, 255)));
      din_vld = ($urandom_range(0, 9) < 6);
      req     = ($urandom_range(0, 9) < 3);
      done    = ($urandom_range(0, 9) < 3);
      cycle();
      checks++;
      if (cnt !== 4'(mq.size()) || empty !== (mq.size() == 0) || rdy !== (mq.size() != D)) begin
        errors++;
        $display("FAIL rand_count n=%0d: cnt=%0d empty=%b rdy=%b, required cnt=%0d", n, cnt, empty, rdy, mq.size());
      end
      checks++;
      if (dvld !== m_vld || busy !== m_busy || err !== m_err) begin
        errors++;
        $display("FAIL rand_ctrl n=%0d: vld=%b busy=%b err=%b, required %b %b %b", n, dvld, busy, err, m_vld, m_busy, m_err);
      end
      checks++;
      if (dout !== m_out || drop !== 8'(m_drop)) begin
        errors++;
        $display("FAIL rand_data n=%0d: dout0=%h drop=%0d, required %h %0d", n, dout[31:0], drop, m_out[31:0], m_drop);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_full_wrap();
    test_drop();
    test_err();
    test_push_pop_same();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu_load_queue.md
IDU_LOAD_QUEUE -- requirements
Module: idu_load_queue

Interface
REQ-001 Parameters SHALL be (name, default, meaning): INSTR_WIDTH, 256, instruction width; DEPTH, 8, queue entries (power of two); LOAD_OPCODE, 8'h01, opcode value in instr[7:0] marking a load instruction.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 dec2idu_instr  in  INSTR_WIDTH  decoded instruction from decoder.
REQ-005 dec2idu_instr_vld  in  1  dec2idu_instr valid this cycle.
REQ-006 idu2dec_instr_rdy  out  1  queue can accept an instruction this cycle.
REQ-007 idu2dfu_load_fifo_empty  out  1  no load instruction queued.
REQ-008 dfu2idu_load_instr_req  in  1  DFU pop request, single-cycle pulse.
REQ-009 idu2dfu_load_instr  out  INSTR_WIDTH  popped instruction, registered.
REQ-010 idu2dfu_load_instr_vld  out  1  one-cycle qualifier for idu2dfu_load_instr.
REQ-011 dfu2idu_load_instr_done  in  1  DFU finished the issued instruction, single-cycle pulse.
REQ-012 idu_load_count  out  $clog2(DEPTH)+1  number of queued entries.
REQ-013 idu_load_drop_cnt  out  8  non-load instructions discarded, saturating.
REQ-014 idu_load_busy  out  1  an instruction is issued and awaiting done.
REQ-015 idu_load_err  out  1  sticky protocol error flag.

Function
REQ-016 Push: handshake SHALL complete when dec2idu_instr_vld && idu2dec_instr_rdy.
REQ-017 idu2dec_instr_rdy SHALL equal (idu_load_count != DEPTH), independent of a same-cycle pop.
REQ-018 Accepted instruction with instr[7:0]==LOAD_OPCODE SHALL be written at the write pointer; count +1.
REQ-019 Accepted instruction with any other opcode SHALL be discarded; idu_load_drop_cnt +1, holding at 255.
REQ-020 idu2dfu_load_fifo_empty SHALL equal (idu_load_count == 0), combinational from registered count.
REQ-021 Pop FSM states SHALL be IDLE, ISSUE, BUSY; idu_load_busy high in ISSUE and BUSY.
REQ-022 IDLE -> ISSUE on dfu2idu_load_instr_req && !empty: head entry registered onto idu2dfu_load_instr, read pointer +1, count -1.
REQ-023 ISSUE SHALL last exactly one cycle with idu2dfu_load_instr_vld=1, then go to BUSY; vld is 0 in every other state.
REQ-024 BUSY -> IDLE on dfu2idu_load_instr_done; done in ISSUE SHALL also return to IDLE.
REQ-025 Latency: vld SHALL rise exactly one cycle after the accepted req cycle.
REQ-026 idu2dfu_load_instr SHALL hold its last value until the next pop.
REQ-027 Push and pop in the same cycle SHALL leave count unchanged; count 0 with same-cycle push SHALL not service the req (req sees empty).
REQ-028 Req in IDLE while empty, req in ISSUE/BUSY, and done in IDLE SHALL be ignored and set idu_load_err.
REQ-029 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-030 Queue order SHALL be strict FIFO for load instructions.

Reset
REQ-031 While rst=1: count, pointers, drop_cnt, err SHALL be 0; FSM IDLE; idu2dfu_load_instr 0; vld 0; busy 0; empty 1; rdy 1.
REQ-032 Reset asserted mid-operation SHALL abandon any issued instruction and flush all entries; queue RAM contents need not be cleared.
REQ-033 First push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Push load instrs A,B,C (opcode 01) then three req pulses each after done -> vld pulses with A,B,C in order, each 1 cycle after req; count 3->0; empty rises after third pop.
REQ-035 Push 8 loads -> rdy=0, count=8; ninth vld held -> not accepted; one pop -> rdy=1 next cycle; push accepted, pointer wraps to 0.
REQ-036 Push opcode 02 then 01 -> drop_cnt=1, count=1; 300 non-load pushes -> drop_cnt saturates at 255.
REQ-037 Req with count 0 -> no vld, err=1 sticky; req during BUSY -> ignored, count unchanged, err=1.
REQ-038 Count=1, simultaneous push and req -> vld next cycle with old head, count stays 1.
REQ-039 Assert rst while BUSY with count 4 -> immediately busy=0, count=0, empty=1, vld=0; later done pulse -> ignored, err sets only after reset release.
